// File: rtl/mult_unit_pkg.sv
// Shared multiply definitions: FSM states, iteration count, and the func codes
// that the decode stage maps onto i_signed.
package mult_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mult_state_e;

  localparam int unsigned MULT_CYCLES = 32;

  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_MADD  = 6'h00;
  localparam logic [5:0] FUNC_MADDU = 6'h01;
  localparam logic [5:0] FUNC_MSUB  = 6'h04;
  localparam logic [5:0] FUNC_MSUBU = 6'h05;

  // Helper for the decode stage: which func codes use two's-complement operands.
  function automatic logic func_is_signed(input logic [5:0] func);
    return (func == FUNC_MULT) || (func == FUNC_MADD) || (func == FUNC_MSUB);
  endfunction

  function automatic logic func_is_unsigned(input logic [5:0] func);
    return (func == FUNC_MULTU) || (func == FUNC_MADDU) || (func == FUNC_MSUBU);
  endfunction

  // Operand magnitude; 0x80000000 maps to 2^31 as an unsigned 32-bit value.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_unit.sv
// Iterative 32x32 -> 64 radix-2 shift-add multiplier with fixed 32-cycle latency,
// cancel/flush support and back-to-back issue from the DONE state.
module mult_unit
  import mult_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic        i_cancel,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result_hi,
  output logic [31:0] o_result_lo
);

  mult_state_e state_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic        sign_q;
  logic        busy_q;
  logic        done_q;
  logic [63:0] result_q;

  logic [31:0] mag_a_d;
  logic [31:0] mag_b_d;
  logic        sign_d;
  logic [63:0] acc_d;
  logic [63:0] prod_d;
  logic        last_iter;

  assign mag_a_d   = mag32(i_op_a, i_signed);
  assign mag_b_d   = mag32(i_op_b, i_signed);
  assign sign_d    = i_signed & (i_op_a[31] ^ i_op_b[31]);
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_d    = sign_q ? (~acc_d + 64'd1) : acc_d;
  assign last_iter = (cnt_q == 6'(MULT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_CALC: begin
          if (i_cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 6'd1;
            if (last_iter) begin
              result_q <= prod_d;
              cnt_q    <= '0;
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE share the accept path, giving back-to-back issue from DONE.
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= S_IDLE;
          if (i_start && !i_cancel) begin
            state_q  <= S_CALC;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {32'h0, mag_a_d};
            mplier_q <= mag_b_d;
            sign_q   <= sign_d;
          end
        end
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_result_hi = result_q[63:32];
  assign o_result_lo = result_q[31:0];

endmodule

// File: tb/tb_mult_unit.sv
// Directed and randomized checks of mult_unit against an arithmetic reference
// product, including cancel, reset, back-to-back and latency behaviour.
module tb_mult_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] prev_res;

  mult_unit dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_signed   (sgn),
    .i_op_a     (op_a),
    .i_op_b     (op_b),
    .i_cancel   (cancel),
    .o_busy     (busy),
    .o_done     (done),
    .o_result_hi(res_hi),
    .o_result_lo(res_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  // Issue one multiply (from IDLE or from a DONE cycle) and follow it to o_done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input string tag);
    logic [63:0] exp;
    int unsigned n;
    int unsigned busy_n;
    logic held;
    exp    = model(a, b, s);
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    sgn    = s;
    tick();
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    n      = 0;
    busy_n = 0;
    held   = 1'b1;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if ({res_hi, res_lo} !== prev_res) held = 1'b0;
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd32);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd32);
    check({tag, " result_held"}, 64'(held), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " product"}, {res_hi, res_lo}, exp);
    prev_res = exp;
  endtask

  task automatic quiet_window(input string tag);
    int unsigned done_n;
    int unsigned busy_n;
    done_n = 0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_n++;
      if (busy) busy_n++;
      tick();
    end
    check({tag, " no_done"}, 64'(done_n), 64'd0);
    check({tag, " no_busy"}, 64'(busy_n), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    rst    = 1'b1;
    start  = 1'b0;
    sgn    = 1'b0;
    op_a   = '0;
    op_b   = '0;
    cancel = 1'b0;
    prev_res = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", {res_hi, res_lo}, 64'd0);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");
    check("umax const", {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);
    tick();
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "neg1x1");
    check("neg1x1 const", {res_hi, res_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "smin2");
    check("smin2 const", {res_hi, res_lo}, 64'h4000_0000_0000_0000);
    tick();
    run_op(32'h8000_0000, 32'h0000_0002, 1'b0, "u80x2");
    check("u80x2 const", {res_hi, res_lo}, 64'h0000_0001_0000_0000);
    tick();
    run_op(32'h0, 32'h0, 1'b1, "zero");
    tick();

    // Restart attempt in CALC is ignored, then a cancel aborts 7x9.
    run_op(32'd3, 32'd5, 1'b0, "3x5");
    tick();
    start = 1'b1; op_a = 32'd7; op_b = 32'd9; sgn = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b1; op_a = 32'd100; op_b = 32'd200;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("cancel busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel done", 64'(done), 64'd0);
    check("cancel result", {res_hi, res_lo}, 64'h0000_0000_0000_000F);
    quiet_window("cancel");

    // Back-to-back issue from the DONE cycle.
    run_op(32'd2, 32'd3, 1'b0, "2x3");
    check("2x3 done", 64'(done), 64'd1);
    run_op(32'd11, 32'hFFFF_FFF3, 1'b1, "b2b");

    // Cancel during DONE ends the pulse and suppresses a simultaneous start.
    start = 1'b1; cancel = 1'b1; op_a = 32'd5; op_b = 32'd5;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("done_cancel done", 64'(done), 64'd0);
    check("done_cancel busy", 64'(busy), 64'd0);
    check("done_cancel result", {res_hi, res_lo}, prev_res);

    // Reset mid-CALC.
    start = 1'b1; op_a = 32'd7; op_b = 32'd9; sgn = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; start = 1'b1; cancel = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; cancel = 1'b0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", {res_hi, res_lo}, 64'd0);
    prev_res = '0;
    tick();
    run_op(32'd4, 32'd4, 1'b0, "4x4");
    check("4x4 const", {res_hi, res_lo}, 64'h10);
    tick();

    // Start together with cancel from IDLE.
    start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    quiet_window("start_cancel");

    // Randomized operands, mixing corner values, signedness and back-to-back issue.
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h0;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, $sformatf("rand%0d", k));
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32, product width 64.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 i_clk  input  1  rising-edge clock for all state.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_start  input  1  request a new multiply; sampled only when not busy.
REQ-006 i_signed  input  1  1 = MULT/MADD/MSUB (two's complement), 0 = MULTU/MADDU/MSUBU.
REQ-007 i_op_a  input  32  multiplicand (rs).
REQ-008 i_op_b  input  32  multiplier (rt).
REQ-009 i_cancel  input  1  pipeline flush; aborts any operation in flight.
REQ-010 o_busy  output  1  high while a multiply is iterating.
REQ-011 o_done  output  1  one-cycle pulse; product valid on o_result_* during this cycle.
REQ-012 o_result_hi  output  32  product bits 63:32, feeds the HI/LO accumulate stage's i_mult_hi.
REQ-013 o_result_lo  output  32  product bits 31:0, feeds that stage's i_mult_lo.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 IDLE: o_busy=0, o_done=0. If i_start=1 and i_cancel=0, go to CALC. Operands latched at that edge.
REQ-016 Latching: store |i_op_a|, |i_op_b| (absolute value when i_signed=1, raw otherwise) and sign = i_signed & (a[31]^b[31]). Magnitude of 0x80000000 is 2^31, unsigned 32-bit.
REQ-017 CALC: radix-2 shift-add, one multiplier bit per edge, 6-bit iteration counter from 0. o_busy=1.
REQ-018 On the 32nd CALC edge, register the product, two's-complement negated over 64 bits if sign=1, into o_result_*. Go to DONE.
REQ-019 DONE: o_done=1 and o_busy=0 for exactly one cycle. o_done rises 32 edges after the edge that accepted i_start.
REQ-020 DONE: i_start=1 is accepted and goes directly to CALC (back-to-back, no IDLE bubble). Otherwise go to IDLE.
REQ-021 i_start while in CALC SHALL be ignored; latched operands stay unchanged.
REQ-022 o_result_* SHALL hold the last completed product until the next completion or reset. They SHALL not change during CALC.
REQ-023 i_cancel=1 in CALC or DONE: next state IDLE, no o_done pulse (in DONE the current pulse is not extended). o_result_* keep their prior completed value.
REQ-024 i_cancel and i_start asserted together in any state: cancel wins, no operation starts.
REQ-025 Zero operands SHALL still take the full 32 iterations (fixed latency, no early termination).

Reset
REQ-026 i_rst=1 at an edge, in any state including mid-CALC: state=IDLE, counter=0, o_busy=0, o_done=0, o_result_hi=0, o_result_lo=0, internal accumulators=0.
REQ-027 i_rst SHALL take priority over i_start and i_cancel.

Structure
REQ-028 State encodings and MULT_CYCLES=32 SHALL live in the shared OP.v include, alongside the FUNC_MULT/FUNC_MULTU/FUNC_MADD* codes.
REQ-029 Decoding from instruction func to i_signed SHALL happen outside this block.
REQ-030 No sub-module is required. Absolute value and 64-bit negation are inline logic.

Verification
REQ-031 Unsigned: 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. o_done exactly 32 edges after start. o_busy high 32 cycles.
REQ-032 Signed: 0xFFFFFFFF (-1) x 0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. Unsigned 0x80000000 x 0x00000002 -> hi=0x00000001, lo=0.
REQ-033 Sequence: complete 3x5, then start 7x9, pulse i_start again at CALC cycle 4 with other operands, then i_cancel at cycle 10 -> no o_done, o_busy drops next edge, result remains hi=0, lo=0x0000000F.
REQ-034 Back-to-back: assert i_start with new operands during the DONE cycle of 2x3 -> first o_done shows 6, second o_done 32 edges later shows the new product, no IDLE cycle between.
REQ-035 Reset at CALC cycle 5 -> next cycle all outputs 0, state IDLE. A later start of 4x4 yields lo=0x10 at the normal latency.
REQ-036 i_start with i_cancel together from IDLE -> o_busy stays 0, no o_done within 40 cycles.
